// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned WIDTH x WIDTH multiplier
// built from one adder. Each BUSY cycle retires one multiplier bit.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req_valid/ready request handshake; a_i, b_i sampled on accept
//   resp_valid/ready response handshake; product_o = a*b (2*WIDTH bits)
//
// Build option: SHIFT_ADD_MULT_EARLY_TERM_EN ends BUSY as soon as the
// remaining multiplier bits are all zero (latency = msb index of b + 1).

module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_n;

    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic                 accept;
    logic                 release_res;
    logic                 last_bit;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign product_o  = acc;

    assign accept      = req_valid && req_ready;
    assign release_res = resp_valid && resp_ready;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    // Bits above the LSB are what remains after this edge's shift; once
    // they are zero no further additions can change the accumulator.
    assign last_bit = (cnt == LAST) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_bit = (cnt == LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (last_bit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (release_res) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath. The accumulator doubles as the result register, so it is
    // only written on accept and in BUSY; it is frozen through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= {{WIDTH{1'b0}}, a_i};
                        mplier <= b_i;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed + back-to-back checks of the
// shift/add multiplier against a queue of expected products.

module tb_shift_add_multiplier;

    localparam int W = 8;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [W-1:0]    a_i;
    logic [W-1:0]    b_i;
    logic            resp_valid;
    logic            resp_ready;
    logic [2*W-1:0]  product_o;

    int pass_cnt = 0;
    int total    = 0;

    longint unsigned exp_q[$];

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a_i        (a_i),
        .b_i        (b_i),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .product_o  (product_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint unsigned obs,
                       input longint unsigned exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL %s: observed %0d expected <none queued>",
                   tag, product_o);
        end else begin
            chk(tag, longint'(product_o), exp_q.pop_front());
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
        int l;
        l = W;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        l = 1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) l = i + 1;
        end
`endif
        return l;
    endfunction

    // One complete request/response; the consumer is ready once the
    // result has been observed.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input string tag);
        int lat;
        chk({tag, "_req_ready"}, req_ready, 1);
        a_i = a;
        b_i = b;
        req_valid = 1'b1;
        exp_q.push_back(longint'(a) * longint'(b));
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat(b));
        pop_chk({tag, "_product"});
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, resp_valid, 0);
        chk({tag, "_ready_back"}, req_ready, 1);
    endtask

    initial begin
        int lat;
        int cyc;
        int n_acc;
        int n_res;
        int last_res;
        logic acc_now;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        a_i        = '0;
        b_i        = '0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_product", product_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic and max-operand cases.
        do_op(8'd3, 8'd5, "basic");
        do_op(8'd255, 8'd255, "max");
        do_op(8'd0, 8'd200, "a_zero");

        // Operands that exercise early termination.
        do_op(8'd9, 8'd1, "b_one");
        do_op(8'd77, 8'd0, "b_zero");
        do_op(8'd3, 8'h10, "b_16");
        do_op(8'd1, 8'h80, "b_msb");

        // Backpressure: result held while consumer stalls, new requests
        // ignored.
        a_i = 8'd11;
        b_i = 8'd13;
        req_valid = 1'b1;
        exp_q.push_back(64'd143);
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("bp_latency", lat, exp_lat(8'd13));
        pop_chk("bp_product");
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0);
            a_i = 8'd7;
            b_i = 8'd7;
            step();
            chk("bp_hold_valid", resp_valid, 1);
            chk("bp_hold_product", product_o, 143);
            chk("bp_hold_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("bp_release_valid", resp_valid, 0);
        chk("bp_release_ready", req_ready, 1);
        chk("bp_nothing_queued", exp_q.size(), 0);

        // Reset in the middle of an operation.
        a_i = 8'd200;
        b_i = 8'd100;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_product", product_o, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        resp_ready = 1'b0;
        step();
        rst_n = 1'b1;
        do_op(8'd12, 8'd12, "post_rst");

        // Back-to-back: request held valid, consumer always ready.
        n_acc = 0;
        n_res = 0;
        last_res = -1;
        cyc = 0;
        a_i = W'($urandom);
        b_i = W'($urandom);
        req_valid = 1'b1;
        resp_ready = 1'b1;
        while (n_res < 20 && cyc < 2000) begin
            acc_now = req_valid && req_ready;
            if (acc_now) begin
                exp_q.push_back(longint'(a_i) * longint'(b_i));
                if (n_acc > 0) chk("b2b_gap", cyc, last_res + 1);
                n_acc++;
            end
            if (resp_valid) begin
                pop_chk("b2b_product");
                last_res = cyc;
                n_res++;
            end
            step();
            cyc++;
            if (acc_now) begin
                if (n_acc < 20) begin
                    a_i = W'($urandom);
                    b_i = W'($urandom);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        resp_ready = 1'b0;
        chk("b2b_in_time", (cyc < 2000), 1);
        chk("b2b_results", n_res, 20);
        chk("b2b_requests", n_acc, 20);
        chk("b2b_queue_empty", exp_q.size(), 0);
        step();
        chk("b2b_idle", req_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  operands a_i/b_i are valid.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port a_i  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port b_i  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port resp_valid  output  1  product_o holds a finished result.
REQ-009 SHALL have port resp_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port product_o  output  2*WIDTH  unsigned product a*b.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 SHALL assert req_ready only in IDLE and resp_valid only in DONE; both are registered-state decodes.
REQ-013 SHALL accept a request on the rising edge where req_valid && req_ready, latching a_i into a 2*WIDTH multiplicand register, b_i into a WIDTH multiplier register, clearing accumulator and bit counter, and entering BUSY.
REQ-014 SHALL, on each BUSY edge: add multiplicand to accumulator when multiplier LSB is 1; shift multiplicand left by 1; shift multiplier right by 1; increment counter.
REQ-015 SHALL leave BUSY for DONE on the edge that processes bit WIDTH-1; resp_valid is high in the cycle following the WIDTH-th BUSY edge (latency WIDTH cycles from acceptance).
REQ-016 SHALL drive product_o from the accumulator and hold it stable for as long as DONE persists, regardless of a_i/b_i/req_valid.
REQ-017 SHALL leave DONE for IDLE on the edge where resp_valid && resp_ready; req_ready rises in the following cycle (no same-cycle accept-on-complete).
REQ-018 SHALL ignore req_valid while in BUSY or DONE; no request is queued.
REQ-019 SHALL compute the full 2*WIDTH-bit product with no truncation or overflow (max (2^WIDTH-1)^2).
REQ-020 SHALL keep resp_valid low while resp_ready is high in IDLE/BUSY; resp_ready outside DONE has no effect.

Reset
REQ-021 SHALL, while rst_n is low, immediately force FSM to IDLE, req_ready=1, resp_valid=0, product_o=0, counter=0, regardless of clk.
REQ-022 SHALL abandon any in-progress or unconsumed result when reset asserts mid-operation; after rst_n deasserts, the first rising edge may accept a new request.

Configuration
REQ-023 SHALL support macro SHIFT_ADD_MULT_EARLY_TERM_EN.
REQ-024 SHALL, with SHIFT_ADD_MULT_EARLY_TERM_EN defined, move BUSY to DONE on the edge where the shifted multiplier becomes zero; latency = (index of highest set bit of b)+1, minimum 1 (b=0 gives latency 1, product 0).
REQ-025 SHALL, without the macro, use fixed latency WIDTH for all operands; product values are identical in both builds.

Verification (WIDTH=8)
REQ-026 SHALL test basic: a=3, b=5 accepted at edge E0 -> resp_valid high after E8, product_o=15 (no macro).
REQ-027 SHALL test max operands: a=255, b=255 -> product_o=65025 (0xFE01), latency 8 in both builds.
REQ-028 SHALL test backpressure: resp_ready low 5 cycles after DONE -> product_o and resp_valid stable; req_valid pulses with a=7,b=7 ignored; release -> IDLE next edge, req_ready high one cycle later.
REQ-029 SHALL test reset mid-op: a=200,b=100, assert rst_n low after 3 BUSY edges -> resp_valid=0, product_o=0, req_ready=1 asynchronously; next request a=12,b=12 yields 144.
REQ-030 SHALL test early term (macro defined): b=1,a=9 -> product 9 latency 1; b=0 -> product 0 latency 1; b=0x10,a=3 -> product 48 latency 5.
REQ-031 SHALL test back-to-back: 20 random requests with req_valid held high and resp_ready high -> every product matches a*b, exactly one result per request, idle gap of one cycle between results.
